// File: rtl/csa_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csa_seq_pkg: shared state encoding, counter limits, chunk derivation |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package csa_seq_pkg;

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_RESOLVE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef enum logic [1:0] {
    S_ACCUM   = ST_ACCUM,
    S_RESOLVE = ST_RESOLVE,
    S_DONE    = ST_DONE
  } state_e;

  localparam int                 COUNT_W   = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 8'd255;

  function automatic int calc_nchunk(input int acc_width, input int chunk);
    return acc_width / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_accum_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csa_accum_step: combinational 3:2 compressor folding X into (S, C)    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module csa_accum_step #(
  parameter int ACC_WIDTH = 24
) (
  input  logic [ACC_WIDTH-1:0] s_in,
  input  logic [ACC_WIDTH-1:0] c_in,
  input  logic [ACC_WIDTH-1:0] x_in,
  output logic [ACC_WIDTH-1:0] s_out,
  output logic [ACC_WIDTH-1:0] c_out
);

  logic [ACC_WIDTH-1:0] c2;

  // Stored carries carry weight 2; the top bit falls off modulo 2^ACC_WIDTH.
  assign c2    = {c_in[ACC_WIDTH-2:0], 1'b0};
  assign s_out = s_in ^ c2 ^ x_in;
  assign c_out = (s_in & c2) | (s_in & x_in) | (c2 & x_in);

endmodule
`default_nettype wire

// File: rtl/csa_accum_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csa_accum_sequencer: carry-save stream accumulator, chunked resolve   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module csa_accum_sequencer
  import csa_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CHUNK     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [COUNT_W-1:0]   out_count,
  output logic                 busy
);

  localparam int                NCHUNK     = calc_nchunk(ACC_WIDTH, CHUNK);
  localparam int                CIDX_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NCHUNK - 1);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] s_q, s_d;
  logic [ACC_WIDTH-1:0] c_q, c_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [CIDX_W-1:0]    chunk_q, chunk_d;
  logic                 cy_q, cy_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [COUNT_W-1:0]   out_count_q, out_count_d;

  logic [ACC_WIDTH-1:0] x_ext;
  logic [ACC_WIDTH-1:0] step_s;
  logic [ACC_WIDTH-1:0] step_c;
  logic [ACC_WIDTH-1:0] c2;
  logic [CHUNK-1:0]     sel_s;
  logic [CHUNK-1:0]     sel_c;
  logic [CHUNK:0]       chunk_sum;
  logic [ACC_WIDTH-1:0] resolved;
  logic                 xfer;

  assign x_ext = ACC_WIDTH'(in_data);
  assign c2    = {c_q[ACC_WIDTH-2:0], 1'b0};

  csa_accum_step #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_step (
    .s_in (s_q),
    .c_in (c_q),
    .x_in (x_ext),
    .s_out(step_s),
    .c_out(step_c)
  );

  // One chunk of the carry-propagate add; the result replaces that chunk of S.
  always_comb begin
    sel_s    = '0;
    sel_c    = '0;
    resolved = s_q;
    for (int k = 0; k < NCHUNK; k++) begin
      if (chunk_q == CIDX_W'(k)) begin
        sel_s = s_q[k*CHUNK +: CHUNK];
        sel_c = c2[k*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, sel_s} + {1'b0, sel_c} + {{CHUNK{1'b0}}, cy_q};
    for (int k = 0; k < NCHUNK; k++) begin
      if (chunk_q == CIDX_W'(k)) begin
        resolved[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      end
    end
  end

  assign in_ready = rst_n & (state_q == S_ACCUM);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    count_d     = count_q;
    chunk_d     = chunk_q;
    cy_d        = cy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    case (state_q)
      S_ACCUM: begin
        if (xfer) begin
          s_d = step_s;
          c_d = step_c;
          if (count_q != COUNT_MAX) begin
            count_d = count_q + 1'b1;
          end
          if (in_last) begin
            state_d = S_RESOLVE;
            chunk_d = '0;
            cy_d    = 1'b0;
          end
        end
      end
      S_RESOLVE: begin
        s_d     = resolved;
        cy_d    = chunk_sum[CHUNK];
        chunk_d = chunk_q + 1'b1;
        if (chunk_q == LAST_CHUNK) begin
          state_d     = S_DONE;
          chunk_d     = '0;
          cy_d        = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = resolved;
          out_count_d = count_q;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_ACCUM;
          out_valid_d = 1'b0;
          s_d         = '0;
          c_d         = '0;
          count_d     = '0;
        end
      end
      default: begin
        state_d = S_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      count_q     <= '0;
      chunk_q     <= '0;
      cy_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      count_q     <= count_d;
      chunk_q     <= chunk_d;
      cy_q        <= cy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign busy      = (state_q != S_ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_csa_accum_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_csa_accum_sequencer: directed vectors for csa_accum_sequencer      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_csa_accum_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [7:0]  out_count;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  csa_accum_sequencer #(
    .WIDTH    (16),
    .ACC_WIDTH(24),
    .CHUNK    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [15:0] base;
    logic [15:0] step;
    logic [23:0] exp_data;
    logic [7:0]  exp_count;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one beat from a negedge and returns just after the edge that takes it.
  task automatic send_beat(input logic [15:0] d, input logic last);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
  endtask

  // Called right after the last beat's edge: checks the 3-cycle latency,
  // optional DONE backpressure, then the result handshake.
  task automatic finish_seq(input string tag, input logic [23:0] exp_d,
                            input logic [7:0] exp_c, input int hold);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      check({tag, "_lat_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_lat_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(exp_d));
    check({tag, "_count"}, 32'(out_count), 32'(exp_c));
    check({tag, "_busy"},  32'(busy),      32'd1);
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data  = 16'h1234;
      in_last  = 1'b1;
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_data"},  32'(out_data),  32'(exp_d));
        check({tag, "_hold_count"}, 32'(out_count), 32'(exp_c));
        check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(in_ready),  32'd1);
    check({tag, "_rel_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    vecs[0] = '{n: 10,  base: 16'h0001, step: 16'h0001, exp_data: 24'h000037, exp_count: 8'd10};
    vecs[1] = '{n: 1,   base: 16'hFFFF, step: 16'h0000, exp_data: 24'h00FFFF, exp_count: 8'd1};
    vecs[2] = '{n: 300, base: 16'hFFFF, step: 16'h0000, exp_data: 24'h2BFED4, exp_count: 8'd255};
    vecs[3] = '{n: 5,   base: 16'h1000, step: 16'h1000, exp_data: 24'h00F000, exp_count: 8'd5};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        send_beat(vecs[v].base + 16'(vecs[v].step * i), (i == vecs[v].n - 1));
      end
      finish_seq($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_count, 0);
    end

    // Carries ripple across chunk boundaries 0->1->2.
    send_beat(16'h8000, 1'b0);
    send_beat(16'h8000, 1'b0);
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'h0001, 1'b1);
    finish_seq("chunk_carry", 24'h020000, 8'd4, 0);

    // DONE backpressure with in_valid held high must not consume anything.
    out_ready = 1'b0;
    send_beat(16'h0010, 1'b0);
    send_beat(16'h0020, 1'b1);
    finish_seq("bp", 24'h000030, 8'd2, 5);
    send_beat(16'h0002, 1'b0);
    send_beat(16'h0003, 1'b1);
    finish_seq("after_bp", 24'h000005, 8'd2, 0);

    // Reset asserted while chunk 1 is pending.
    send_beat(16'h00FF, 1'b0);
    send_beat(16'h0100, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready_gated", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    send_beat(16'h0003, 1'b0);
    send_beat(16'h0004, 1'b1);
    finish_seq("post_mid_rst", 24'h000007, 8'd2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
